// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - NUM_PINS GPIO controller on the peripheral dbus
//
// Purpose: pad output/enable registers with atomic set/clear/toggle, a
// SYNC_STAGES-deep input synchroniser, and per-pin level/edge interrupts
// with write-1-to-clear pending bits.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   gpio_sel_i   peripheral select from the address decoder
//   dbus2gpio_i  bus request (addr, w_data, w_en, req)
//   gpio2dbus_o  bus response (r_data, ack)
//   gpio_in_i    asynchronous pad inputs
//   gpio_out_o   pad output values (OUT register)
//   gpio_oe_o    pad output enables (DIR register, 1 = output)
//   gpio_irq_o   interrupt request, |(IE & IP)

package dbus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

endpackage

module gpio_ctrl
  import dbus_pkg::*;
#(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gpio_sel_i,
  input  type_dbus2peri_s     dbus2gpio_i,
  output type_peri2dbus_s     gpio2dbus_o,
  input  logic [NUM_PINS-1:0] gpio_in_i,
  output logic [NUM_PINS-1:0] gpio_out_o,
  output logic [NUM_PINS-1:0] gpio_oe_o,
  output logic                gpio_irq_o
);

  localparam logic [7:0] ADDR_OUT      = 8'h00;
  localparam logic [7:0] ADDR_IN       = 8'h04;
  localparam logic [7:0] ADDR_DIR      = 8'h08;
  localparam logic [7:0] ADDR_OUT_SET  = 8'h0C;
  localparam logic [7:0] ADDR_OUT_CLR  = 8'h10;
  localparam logic [7:0] ADDR_OUT_TGL  = 8'h14;
  localparam logic [7:0] ADDR_IE       = 8'h18;
  localparam logic [7:0] ADDR_IP       = 8'h1C;
  localparam logic [7:0] ADDR_INT_TYPE = 8'h20;
  localparam logic [7:0] ADDR_INT_POL  = 8'h24;
  localparam logic [7:0] ADDR_INT_ANY  = 8'h28;

  // register state
  logic [NUM_PINS-1:0] out_q, out_d;
  logic [NUM_PINS-1:0] dir_q, dir_d;
  logic [NUM_PINS-1:0] ie_q, ie_d;
  logic [NUM_PINS-1:0] ip_q, ip_d;
  logic [NUM_PINS-1:0] type_q, type_d;
  logic [NUM_PINS-1:0] pol_q, pol_d;
  logic [NUM_PINS-1:0] any_q, any_d;

  // input synchroniser; the last stage is the IN register
  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
  logic [NUM_PINS-1:0]                  in_prev_q;
  logic [NUM_PINS-1:0]                  in_sync;

  // bus response
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  // bus decode
  logic                rd_req, wr_req;
  logic                rd_fire, wr_fire;
  logic [7:0]          reg_addr;
  logic [NUM_PINS-1:0] wdata;
  logic [NUM_PINS-1:0] ip_clr;
  logic [NUM_PINS-1:0] rd_val;
  logic [31:0]         rd_word;

  // interrupt events
  logic [NUM_PINS-1:0] rise, fall, ev;

  // Address bits above the register window and data bits above NUM_PINS
  // are deliberately ignored.
  logic unused_bus;
  assign unused_bus = ^{dbus2gpio_i.addr[31:8], dbus2gpio_i.w_data};

  assign reg_addr = dbus2gpio_i.addr[7:0];
  assign wdata    = dbus2gpio_i.w_data[NUM_PINS-1:0];

  assign rd_req = dbus2gpio_i.req & ~dbus2gpio_i.w_en & gpio_sel_i;
  assign wr_req = dbus2gpio_i.req &  dbus2gpio_i.w_en & gpio_sel_i;

  // A request is serviced only in a cycle where no ack is being driven, so
  // a held request acks every other cycle and a write lands exactly once.
  assign rd_fire = rd_req & ~ack_q;
  assign wr_fire = wr_req & ~ack_q;
  assign ack_d   = (rd_req | wr_req) & ~ack_q;

  assign in_sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Synchroniser shift
  // ---------------------------------------------------------------------
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = gpio_in_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // ---------------------------------------------------------------------
  // Per-pin event detection
  // ---------------------------------------------------------------------
  assign rise = in_sync & ~in_prev_q;
  assign fall = ~in_sync & in_prev_q;

  always_comb begin
    ev = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (type_q[i]) begin
        // edge mode; ANY overrides the polarity selection
        if (any_q[i]) begin
          ev[i] = rise[i] | fall[i];
        end else if (pol_q[i]) begin
          ev[i] = rise[i];
        end else begin
          ev[i] = fall[i];
        end
      end else begin
        // level mode
        ev[i] = pol_q[i] ? in_sync[i] : ~in_sync[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------
  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ie_d   = ie_q;
    type_d = type_q;
    pol_d  = pol_q;
    any_d  = any_q;
    ip_clr = '0;
    if (wr_fire) begin
      case (reg_addr)
        ADDR_OUT:      out_d  = wdata;
        ADDR_DIR:      dir_d  = wdata;
        ADDR_OUT_SET:  out_d  = out_q | wdata;
        ADDR_OUT_CLR:  out_d  = out_q & ~wdata;
        ADDR_OUT_TGL:  out_d  = out_q ^ wdata;
        ADDR_IE:       ie_d   = wdata;
        ADDR_IP:       ip_clr = wdata;
        ADDR_INT_TYPE: type_d = wdata;
        ADDR_INT_POL:  pol_d  = wdata;
        ADDR_INT_ANY:  any_d  = wdata;
        default:       ip_clr = '0;
      endcase
    end
  end

  // Edge-mode pins are sticky and a new event wins over a same-cycle clear;
  // level-mode pins simply follow the event and ignore writes. The mode in
  // force before this cycle's write decides which rule applies.
  assign ip_d = (type_q & (ev | (ip_q & ~ip_clr))) | (~type_q & ev);

  // ---------------------------------------------------------------------
  // Register reads
  // ---------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    case (reg_addr)
      ADDR_OUT:      rd_val = out_q;
      ADDR_IN:       rd_val = in_sync;
      ADDR_DIR:      rd_val = dir_q;
      ADDR_IE:       rd_val = ie_q;
      ADDR_IP:       rd_val = ip_q;
      ADDR_INT_TYPE: rd_val = type_q;
      ADDR_INT_POL:  rd_val = pol_q;
      ADDR_INT_ANY:  rd_val = any_q;
      default:       rd_val = '0;
    endcase
  end

  always_comb begin
    rd_word                 = '0;
    rd_word[NUM_PINS-1:0]   = rd_val;
  end

  // r_data is only non-zero in the ack cycle of a read
  assign rdata_d = rd_fire ? rd_word : 32'h0;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      ie_q      <= '0;
      ip_q      <= '0;
      type_q    <= '0;
      pol_q     <= '0;
      any_q     <= '0;
      sync_q    <= '0;
      in_prev_q <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      ie_q      <= ie_d;
      ip_q      <= ip_d;
      type_q    <= type_d;
      pol_q     <= pol_d;
      any_q     <= any_d;
      sync_q    <= sync_d;
      in_prev_q <= in_sync;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign gpio_out_o  = out_q;
  assign gpio_oe_o   = dir_q;
  assign gpio_irq_o  = |(ie_q & ip_q);
  assign gpio2dbus_o = type_peri2dbus_s'{r_data: rdata_q, ack: ack_q};

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - self-checking bench for gpio_ctrl
module tb_gpio_ctrl;
  import dbus_pkg::*;

  localparam int NP = 8;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            sel;
  type_dbus2peri_s d2p;
  type_peri2dbus_s p2d, p2d5;
  logic [NP-1:0]   pad, out, oe;
  logic            irq;
  logic [4:0]      out5, oe5;
  logic            irq5;

  int total = 0;
  int bad   = 0;

  gpio_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .gpio_sel_i(sel), .dbus2gpio_i(d2p),
    .gpio2dbus_o(p2d), .gpio_in_i(pad), .gpio_out_o(out),
    .gpio_oe_o(oe), .gpio_irq_o(irq)
  );

  gpio_ctrl #(.NUM_PINS(5), .SYNC_STAGES(SS)) dut5 (
    .clk(clk), .rst(rst), .gpio_sel_i(sel), .dbus2gpio_i(d2p),
    .gpio2dbus_o(p2d5), .gpio_in_i(pad[4:0]), .gpio_out_o(out5),
    .gpio_oe_o(oe5), .gpio_irq_o(irq5)
  );

  // ---------------------------------------------------------------------
  // Reference model: register file plus a history of sampled pad values.
  // IN is the pad value sampled SS clock edges ago.
  // ---------------------------------------------------------------------
  logic [7:0]  m_out, m_dir, m_ie, m_ip, m_type, m_pol, m_any, m_prev;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic [7:0]  pq[$];

  always @(posedge clk) begin : model
    logic [7:0] in_now, ev, clr, rd, wd;
    logic       fire, was_ack;
    if (rst) begin
      m_out = 0; m_dir = 0; m_ie = 0; m_ip = 0;
      m_type = 0; m_pol = 0; m_any = 0; m_prev = 0;
      m_ack = 0; m_rdata = 0;
      pq.delete();
      for (int k = 0; k < SS; k++) pq.push_back(8'h00);
    end else begin
      in_now = pq[0];
      for (int i = 0; i < NP; i++) begin
        if (m_type[i]) begin
          if (m_any[i])      ev[i] = in_now[i] != m_prev[i];
          else if (m_pol[i]) ev[i] = in_now[i] && !m_prev[i];
          else               ev[i] = !in_now[i] && m_prev[i];
        end else begin
          ev[i] = m_pol[i] ? in_now[i] : !in_now[i];
        end
      end
      was_ack = m_ack;
      fire    = sel && d2p.req && !was_ack;
      wd      = d2p.w_data[7:0];
      clr     = 0;
      rd      = 0;
      if (fire && !d2p.w_en) begin
        case (d2p.addr[7:0])
          8'h00: rd = m_out;   8'h04: rd = in_now;  8'h08: rd = m_dir;
          8'h18: rd = m_ie;    8'h1C: rd = m_ip;    8'h20: rd = m_type;
          8'h24: rd = m_pol;   8'h28: rd = m_any;   default: rd = 0;
        endcase
      end
      if (fire && d2p.w_en && d2p.addr[7:0] == 8'h1C) clr = wd;
      for (int i = 0; i < NP; i++)
        m_ip[i] = m_type[i] ? (ev[i] || (m_ip[i] && !clr[i])) : ev[i];
      if (fire && d2p.w_en) begin
        case (d2p.addr[7:0])
          8'h00: m_out  = wd;
          8'h08: m_dir  = wd;
          8'h0C: m_out  = m_out | wd;
          8'h10: m_out  = m_out & ~wd;
          8'h14: m_out  = m_out ^ wd;
          8'h18: m_ie   = wd;
          8'h20: m_type = wd;
          8'h24: m_pol  = wd;
          8'h28: m_any  = wd;
          default: ;
        endcase
      end
      m_ack   = sel && d2p.req && !was_ack;
      m_rdata = {24'h0, rd};
      m_prev  = in_now;
      pq.push_back(pad);
      void'(pq.pop_front());
    end
  end

  // One bus transaction: request driven on a falling edge, response sampled
  // on the next falling edge (one rising edge later), then released.
  task automatic bus_xfer(input logic we, input logic [7:0] a, input logic [31:0] wd,
                          output logic ack, output logic [31:0] rd, output logic [31:0] rd5);
    @(negedge clk);
    sel = 1'b1; d2p.req = 1'b1; d2p.w_en = we;
    d2p.addr = {24'h0, a}; d2p.w_data = wd;
    @(negedge clk);
    ack = p2d.ack; rd = p2d.r_data; rd5 = p2d5.r_data;
    sel = 1'b0; d2p.req = 1'b0; d2p.w_en = 1'b0;
  endtask

  task automatic test_reset();
    logic ack; logic [31:0] rd, rd5;
    logic [7:0] addrs[11];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28};
    rst = 1'b1; pad = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out got=%h exp=00", out); end
    total++; if (oe !== 8'h00) begin bad++; $display("FAIL reset_oe got=%h exp=00", oe); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (p2d.ack !== 1'b0 || p2d.r_data !== 32'h0) begin
      bad++; $display("FAIL reset_bus ack=%b rdata=%h exp 0/0", p2d.ack, p2d.r_data); end
    rst = 1'b0;
    foreach (addrs[k]) begin
      bus_xfer(1'b0, addrs[k], 32'h0, ack, rd, rd5);
      // level mode, active-low, pads all low: every pin is pending
      total++;
      if (ack !== 1'b1 || rd !== ((addrs[k] == 8'h1C) ? 32'hFF : 32'h0)) begin
        bad++; $display("FAIL reset_read_%h ack=%b got=%h", addrs[k], ack, rd);
      end
    end
    bus_xfer(1'b1, 8'h00, 32'hA5, ack, rd, rd5);
    total++; if (ack !== 1'b1 || out !== 8'hA5) begin
      bad++; $display("FAIL write_out ack=%b out=%h exp 1/a5", ack, out); end
    bus_xfer(1'b1, 8'h08, 32'hFF, ack, rd, rd5);
    total++; if (ack !== 1'b1 || oe !== 8'hFF || rd !== 32'h0) begin
      bad++; $display("FAIL write_dir ack=%b oe=%h rd=%h exp 1/ff/0", ack, oe, rd); end
  endtask

  task automatic test_atomic();
    logic ack; logic [31:0] rd, rd5;
    bus_xfer(1'b1, 8'h00, 32'hF0, ack, rd, rd5);
    bus_xfer(1'b1, 8'h0C, 32'h0F, ack, rd, rd5);
    bus_xfer(1'b0, 8'h00, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'hFF) begin bad++; $display("FAIL atomic_set got=%h exp=ff", rd); end
    bus_xfer(1'b1, 8'h10, 32'h81, ack, rd, rd5);
    bus_xfer(1'b0, 8'h00, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h7E) begin bad++; $display("FAIL atomic_clr got=%h exp=7e", rd); end
    bus_xfer(1'b1, 8'h14, 32'hFF, ack, rd, rd5);
    total++; if (out !== 8'h81) begin bad++; $display("FAIL atomic_tgl got=%h exp=81", out); end
    for (int k = 0; k < 3; k++) begin
      bus_xfer(1'b0, 8'(8'h0C + 4 * k), 32'h0, ack, rd, rd5);
      total++; if (ack !== 1'b1 || rd !== 32'h0) begin
        bad++; $display("FAIL atomic_read_wo ack=%b got=%h exp=0", ack, rd); end
    end
  endtask

  task automatic test_edge_irq();
    logic ack; logic [31:0] rd, rd5;
    bus_xfer(1'b1, 8'h24, 32'hFF, ack, rd, rd5);
    bus_xfer(1'b1, 8'h20, 32'h01, ack, rd, rd5);
    bus_xfer(1'b1, 8'h1C, 32'hFF, ack, rd, rd5);
    bus_xfer(1'b1, 8'h18, 32'h01, ack, rd, rd5);
    bus_xfer(1'b0, 8'h1C, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL edge_idle ip=%h irq=%b exp 0/0", rd, irq); end
    @(negedge clk); pad[0] = 1'b1;
    repeat (SS) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_early irq=%b exp=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL edge_rise irq=%b exp=1", irq); end
    bus_xfer(1'b0, 8'h1C, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h01) begin bad++; $display("FAIL edge_ip got=%h exp=01", rd); end
    bus_xfer(1'b1, 8'h1C, 32'h01, ack, rd, rd5);
    bus_xfer(1'b0, 8'h1C, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL edge_w1c ip=%h irq=%b exp 0/0", rd, irq); end
    @(negedge clk); pad[0] = 1'b0;
    repeat (SS + 3) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_fall_ignored irq=%b exp=0", irq); end
    bus_xfer(1'b1, 8'h28, 32'h01, ack, rd, rd5);
    @(negedge clk); pad[0] = 1'b1;
    repeat (SS + 3) @(negedge clk);
    bus_xfer(1'b1, 8'h1C, 32'h01, ack, rd, rd5);
    @(negedge clk); pad[0] = 1'b0;
    repeat (SS + 3) @(negedge clk);
    bus_xfer(1'b0, 8'h1C, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h01 || irq !== 1'b1) begin
      bad++; $display("FAIL edge_any_fall ip=%h irq=%b exp 01/1", rd, irq); end
    bus_xfer(1'b1, 8'h28, 32'h00, ack, rd, rd5);
  endtask

  task automatic test_collision();
    logic ack; logic [31:0] rd, rd5;
    bus_xfer(1'b1, 8'h1C, 32'h01, ack, rd, rd5);
    @(negedge clk); pad[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // the clear is sampled on the same edge that registers the rising event
    sel = 1'b1; d2p.req = 1'b1; d2p.w_en = 1'b1; d2p.addr = 32'h1C; d2p.w_data = 32'h01;
    @(negedge clk);
    total++; if (p2d.ack !== 1'b1) begin bad++; $display("FAIL collide_ack got=%b exp=1", p2d.ack); end
    sel = 1'b0; d2p.req = 1'b0; d2p.w_en = 1'b0;
    bus_xfer(1'b0, 8'h1C, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h01) begin bad++; $display("FAIL collide_ip got=%h exp=01", rd); end
    bus_xfer(1'b1, 8'h1C, 32'h01, ack, rd, rd5);
    @(negedge clk); pad[0] = 1'b0;
    repeat (SS + 3) @(negedge clk);
    pad[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sel = 1'b1; d2p.req = 1'b1; d2p.w_en = 1'b0; d2p.addr = 32'h1C;
    @(negedge clk);
    total++; if (p2d.r_data !== 32'h0) begin
      bad++; $display("FAIL ip_pre_update got=%h exp=0", p2d.r_data); end
    sel = 1'b0; d2p.req = 1'b0;
    bus_xfer(1'b0, 8'h1C, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h01) begin bad++; $display("FAIL ip_post_update got=%h exp=01", rd); end
  endtask

  task automatic test_level();
    logic ack; logic [31:0] rd, rd5;
    bus_xfer(1'b1, 8'h20, 32'h00, ack, rd, rd5);
    bus_xfer(1'b1, 8'h24, 32'h02, ack, rd, rd5);
    bus_xfer(1'b1, 8'h18, 32'h02, ack, rd, rd5);
    @(negedge clk); pad[1] = 1'b1;
    repeat (SS + 2) @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL level_irq got=%b exp=1", irq); end
    bus_xfer(1'b1, 8'h1C, 32'h02, ack, rd, rd5);
    bus_xfer(1'b0, 8'h1C, 32'h0, ack, rd, rd5);
    total++; if (rd[1] !== 1'b1) begin bad++; $display("FAIL level_w1c_ignored got=%b exp=1", rd[1]); end
    @(negedge clk); pad[1] = 1'b0;
    repeat (SS) @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL level_hold got=%b exp=1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL level_drop got=%b exp=0", irq); end
    bus_xfer(1'b1, 8'h18, 32'h00, ack, rd, rd5);
  endtask

  task automatic test_handshake();
    logic ack; logic [31:0] rd, rd5;
    bus_xfer(1'b1, 8'h00, 32'h5A, ack, rd, rd5);
    bus_xfer(1'b1, 8'h08, 32'h3C, ack, rd, rd5);
    @(negedge clk);
    sel = 1'b1; d2p.req = 1'b1; d2p.w_en = 1'b0; d2p.addr = 32'h00;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (p2d.ack !== 1'(i % 2) || p2d.r_data !== ((i % 2) ? 32'h5A : 32'h0)) begin
        bad++; $display("FAIL held_req_%0d ack=%b rd=%h", i, p2d.ack, p2d.r_data);
      end
    end
    sel = 1'b0; d2p.req = 1'b0;
    bus_xfer(1'b1, 8'h3C, 32'hFF, ack, rd, rd5);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL unmapped_ack got=%b exp=1", ack); end
    bus_xfer(1'b0, 8'h00, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h5A) begin bad++; $display("FAIL unmapped_out got=%h exp=5a", rd); end
    bus_xfer(1'b0, 8'h08, 32'h0, ack, rd, rd5);
    total++; if (rd !== 32'h3C) begin bad++; $display("FAIL unmapped_dir got=%h exp=3c", rd); end
    bus_xfer(1'b0, 8'h3C, 32'h0, ack, rd, rd5);
    total++; if (ack !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL unmapped_read ack=%b got=%h exp 1/0", ack, rd); end
    bus_xfer(1'b1, 8'h00, 32'hFF, ack, rd, rd5);
    bus_xfer(1'b0, 8'h00, 32'h0, ack, rd, rd5);
    total++; if (rd5 !== 32'h1F || out5 !== 5'h1F) begin
      bad++; $display("FAIL pins5_mask rd=%h out=%h exp 1f/1f", rd5, out5); end
    @(negedge clk);
    sel = 1'b1; d2p.req = 1'b1; d2p.w_en = 1'b0; d2p.addr = 32'h00; rst = 1'b1;
    @(negedge clk);
    total++; if (p2d.ack !== 1'b0 || p2d.r_data !== 32'h0) begin
      bad++; $display("FAIL rst_mid_req ack=%b rd=%h exp 0/0", p2d.ack, p2d.r_data); end
    sel = 1'b0; d2p.req = 1'b0;
    @(negedge clk); rst = 1'b0;
    total++; if (out !== 8'h00) begin bad++; $display("FAIL rst_mid_out got=%h exp=00", out); end
  endtask

  task automatic test_random();
    logic ack; logic [31:0] rd, rd5, wd;
    logic [7:0] addrs[12];
    logic [7:0] a;
    logic       we;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h3C};
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(2, 0) == 0) pad = pad ^ 8'(1 << $urandom_range(7, 0));
      a  = addrs[$urandom_range(11, 0)];
      we = 1'($urandom_range(1, 0));
      wd = $urandom;
      bus_xfer(we, a, wd, ack, rd, rd5);
      total++;
      if (ack !== m_ack || rd !== m_rdata || out !== m_out || oe !== m_dir ||
          irq !== |(m_ie & m_ip)) begin
        bad++;
        $display("FAIL rand_%0d a=%h we=%b ack=%b/%b rd=%h/%h out=%h/%h oe=%h/%h irq=%b/%b",
                 n, a, we, ack, m_ack, rd, m_rdata, out, m_out, oe, m_dir, irq, |(m_ie & m_ip));
      end
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; pad = '0;
    d2p = '0;
    test_reset();
    test_atomic();
    test_edge_irq();
    test_collision();
    test_level();
    test_handshake();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
